fconv_arb: RTL
==============

FCONV_ARB -- requirements
Module: fconv_arb

Interface
REQ-001 SHALL have parameter float, default svfloat::float32: floating-point type for all conversions.
REQ-002 SHALL have parameter width, default 32: integer width in bits.
REQ-003 SHALL have parameter frac, default 0: fractional bits of the fixed-point integer.
REQ-004 SHALL have parameter nreq, default 2: number of requesters, range 2..8.
REQ-005 Derived data width SHALL be DW = max(width, $bits(float)); derived id width SHALL be IW = $clog2(nreq).
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 req_valid  input  nreq  per-requester request valid.
REQ-009 req_ready  output  nreq  per-requester accept; at most one bit set per cycle.
REQ-010 req_op  input  nreq  per-requester opcode: 0 = int-to-float, 1 = float-to-int.
REQ-011 req_signed  input  nreq  per-requester signedness of the integer side.
REQ-012 req_data  input  nreq x DW  per-requester operand, right-aligned.
REQ-013 resp_valid  output  1  result valid.
REQ-014 resp_ready  input  1  result accepted by consumer.
REQ-015 resp_id  output  IW  index of the requester that owns the result.
REQ-016 resp_data  output  DW  result, right-aligned and zero-extended.

Function
REQ-017 SHALL implement FSM states IDLE, CONV and RESP.
REQ-018 In IDLE, if any req_valid is set, SHALL assert req_ready for the round-robin winner, capture its op, signed flag, data and id into the operand register, and go to CONV.
REQ-019 In CONV, SHALL register the selected converter output into the result register, with no handshake, and go to RESP.
REQ-020 In RESP, SHALL hold resp_valid=1 and keep resp_id and resp_data stable until resp_ready=1.
REQ-021 On RESP with resp_ready=1 and any req_valid set, SHALL accept the next winner in the same cycle and go to CONV (back-to-back, 2-cycle throughput).
REQ-022 On RESP with resp_ready=1 and no req_valid set, SHALL go to IDLE.
REQ-023 Latency SHALL be: request accepted at edge t -> resp_valid high from edge t+2.
REQ-024 req_ready SHALL be combinational from req_valid, state and resp_ready; req_ready SHALL never be set for a requester whose req_valid is low.
REQ-025 Round-robin: search SHALL start at last_grant+1 mod nreq; last_grant SHALL update only on accept.
REQ-026 Requests not granted SHALL wait with no loss; the requester holds its valid and data.
REQ-027 For op 0, SHALL convert req_data[width-1:0] int-to-float with the captured signed flag; the result occupies resp_data[$bits(float)-1:0].
REQ-028 For op 1, SHALL convert req_data[$bits(float)-1:0] float-to-int; NaN and out-of-range inputs saturate to the maximum (un)signed value, per the float-to-int converter.
REQ-029 Upper unused bits of resp_data SHALL be zero.

Reset
REQ-030 rst SHALL force state=IDLE, resp_valid=0, resp_id=0, resp_data=0, operand register=0 and last_grant=nreq-1 (requester 0 has first priority).
REQ-031 rst asserted in CONV or RESP SHALL discard the in-flight operation with no response; the first accept SHALL occur at the first edge after rst deasserts.
REQ-032 req_ready SHALL be 0 for every requester while rst=1.

Structure
REQ-033 The opcode enum conv_op_t (ITOF=0, FTOI=1) SHALL reside in shared package svfloat.
REQ-034 The block SHALL instantiate one itof and one ftoi converter, both fed from the operand register, and mux their outputs by the registered op.
REQ-035 The round-robin grant logic SHALL be a sub-module named svfloat_rr_arb (parameter n, inputs req and last, output one-hot gnt).

Verification
REQ-036 Single request: requester 0, op 0, unsigned, data 32'd1, accepted at t -> resp_valid at t+2, resp_data 0x3F800000, resp_id 0.
REQ-037 Float-to-int: requester 1, op 1, signed, data 0xC0400000 -> resp_data 0xFFFFFFFD; same request with data 0x7FC00000 (NaN) -> 0x7FFFFFFF.
REQ-038 Contention: both requesters valid from the first cycle after reset -> grant order 0,1,0,1, and each response carries the matching id.
REQ-039 Backpressure: resp_ready held 0 for 5 cycles in RESP -> resp_valid, resp_id and resp_data stable; no req_ready asserted.
REQ-040 Back-to-back: resp_ready=1 with a request pending in RESP -> accept in the same cycle and next resp_valid 2 cycles later.
REQ-041 Reset mid-op: rst pulsed in CONV -> no response; resp_valid=0; next grant goes to requester 0.

Source files
------------

// File: rtl/svfloat_pkg.sv
// Shared floating-point types, converter opcodes and format helpers.
package svfloat;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] man;
  } float16;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } float32;

  typedef struct packed {
    logic        sign;
    logic [10:0] exp;
    logic [51:0] man;
  } float64;

  typedef enum logic {
    ITOF = 1'b0,
    FTOI = 1'b1
  } conv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    RESP = 2'd2
  } fconv_state_t;

  // Exponent field width for a packed IEEE format of the given total width.
  function automatic int exp_bits(input int fw);
    return (fw == 16) ? 5 : (fw == 64) ? 11 : 8;
  endfunction

endpackage

// File: rtl/svfloat_ftoi.sv
// Float to fixed-point integer, truncating toward zero; NaN saturates to
// the maximum value, out-of-range values clamp to the nearest limit.
module svfloat_ftoi import svfloat::*; #(
  parameter int fw    = 32,
  parameter int width = 32,
  parameter int frac  = 0
) (
  input  logic [fw-1:0]    f,
  input  logic             is_signed,
  output logic [width-1:0] q
);

  localparam int EW = exp_bits(fw);
  localparam int MW = fw - 1 - EW;
  localparam int LW = width + MW + 2;
  localparam logic signed [15:0] BIAS = 16'((1 << (EW - 1)) - 1);
  localparam logic [width+1:0] UMAX = {2'b00, {width{1'b1}}};
  localparam logic [width+1:0] SMAX = {3'b000, {(width-1){1'b1}}};
  localparam logic [width+1:0] SMIN = {2'b00, 1'b1, {(width-1){1'b0}}};

  logic               sgn;
  logic [EW-1:0]      ex;
  logic [MW-1:0]      mn;
  logic               is_nan;
  logic               big;
  logic signed [15:0] sh;
  logic [width+1:0]   mag;

  always_comb begin
    {sgn, ex, mn} = f;
    is_nan = (&ex) & (|mn);
    big    = &ex;
    sh     = $signed({{(16-EW){1'b0}}, ex}) - BIAS + 16'(frac);
    mag    = '0;
    if (ex == '0 || sh < 16'sd0) mag = '0;
    else if (sh > 16'(width))    big = 1'b1;
    else mag = (width+2)'((LW'({1'b1, mn}) << sh[7:0]) >> MW);

    if (is_nan) begin
      q = is_signed ? SMAX[width-1:0] : UMAX[width-1:0];
    end else if (is_signed) begin
      if (sgn) q = (big || mag > SMIN) ? SMIN[width-1:0] : (~mag[width-1:0]) + width'(1);
      else     q = (big || mag > SMAX) ? SMAX[width-1:0] : mag[width-1:0];
    end else begin
      if (sgn) q = '0;
      else     q = (big || mag > UMAX) ? UMAX[width-1:0] : mag[width-1:0];
    end
  end

endmodule

// File: rtl/svfloat_itof.sv
// Fixed-point integer to float, round-to-nearest-even; results below the
// normal range flush to zero, results above it become infinity.
module svfloat_itof import svfloat::*; #(
  parameter int fw    = 32,
  parameter int width = 32,
  parameter int frac  = 0
) (
  input  logic [width-1:0] a,
  input  logic             is_signed,
  output logic [fw-1:0]    f
);

  localparam int EW = exp_bits(fw);
  localparam int MW = fw - 1 - EW;
  localparam int XW = width + MW;
  localparam logic signed [15:0] BIAS = 16'((1 << (EW - 1)) - 1);
  localparam logic signed [15:0] EMAX = 16'((1 << EW) - 1);

  logic                sgn;
  logic [width-1:0]    mag;
  logic [7:0]          lz;
  logic [XW-1:0]       ext;
  logic [MW-1:0]       man;
  logic                guard;
  logic                sticky;
  logic                rnd;
  logic signed [15:0]  e;
  logic [EW+MW-1:0]    em;

  always_comb begin
    sgn = is_signed & a[width-1];
    mag = sgn ? (~a) + width'(1) : a;
    lz  = 8'(width);
    for (int i = 0; i < width; i++) if (mag[i]) lz = 8'(width - 1 - i);
    // normalised magnitude with the implicit leading one dropped
    ext    = XW'({mag << lz, {(MW+1){1'b0}}});
    man    = ext[XW-1 -: MW];
    guard  = ext[width-1];
    sticky = |ext[width-2:0];
    rnd    = guard & (sticky | man[0]);
    e      = BIAS + 16'(width - 1 - frac) - 16'(lz);
    // a mantissa carry from rounding bumps the exponent naturally
    em     = {e[EW-1:0], man} + (EW+MW)'(rnd);
    if (mag == '0 || e <= 16'sd0) f = '0;
    else if (e >= EMAX)           f = {sgn, {EW{1'b1}}, {MW{1'b0}}};
    else                          f = {sgn, em};
  end

endmodule

// File: rtl/svfloat_rr_arb.sv
// Round-robin arbiter: the search starts one past the last granted index.
module svfloat_rr_arb #(
  parameter int n = 2,
  localparam int LW = $clog2(n)
) (
  input  logic [n-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [n-1:0]  gnt
);

  logic [LW:0] cand;
  logic        found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= n; i++) begin
      cand = {1'b0, last} + (LW+1)'(i);
      if (cand >= (LW+1)'(n)) cand = cand - (LW+1)'(n);
      if (!found && req[cand[LW-1:0]]) begin
        gnt[cand[LW-1:0]] = 1'b1;
        found             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fconv_arb.sv
// Shared int<->float converter time-multiplexed between nreq requesters
// with round-robin arbitration and a held response register.
module fconv_arb import svfloat::*; #(
  parameter type float = svfloat::float32,
  parameter int  width = 32,
  parameter int  frac  = 0,
  parameter int  nreq  = 2,
  localparam int FW = $bits(float),
  localparam int DW = (width > FW) ? width : FW,
  localparam int IW = $clog2(nreq)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [nreq-1:0]          req_valid,
  output logic [nreq-1:0]          req_ready,
  input  logic [nreq-1:0]          req_op,
  input  logic [nreq-1:0]          req_signed,
  input  logic [nreq-1:0][DW-1:0]  req_data,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [IW-1:0]            resp_id,
  output logic [DW-1:0]            resp_data
);

  fconv_state_t     state, state_nx;
  logic [nreq-1:0]  gnt;
  logic [IW-1:0]    gnt_idx;
  logic [IW-1:0]    last_grant;
  logic             accept;

  conv_op_t         opnd_op;
  logic             opnd_signed;
  logic [DW-1:0]    opnd_data;
  logic [IW-1:0]    opnd_id;

  logic [FW-1:0]    itof_f;
  logic [width-1:0] ftoi_q;
  logic [DW-1:0]    res;

  svfloat_rr_arb #(.n(nreq)) u_arb (
    .req  (req_valid),
    .last (last_grant),
    .gnt  (gnt)
  );

  svfloat_itof #(.fw(FW), .width(width), .frac(frac)) u_itof (
    .a         (opnd_data[width-1:0]),
    .is_signed (opnd_signed),
    .f         (itof_f)
  );

  svfloat_ftoi #(.fw(FW), .width(width), .frac(frac)) u_ftoi (
    .f         (opnd_data[FW-1:0]),
    .is_signed (opnd_signed),
    .q         (ftoi_q)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < nreq; i++) if (gnt[i]) gnt_idx = IW'(i);
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: if (|req_valid) begin
        accept   = 1'b1;
        state_nx = CONV;
      end
      CONV: state_nx = RESP;
      RESP: if (resp_ready) begin
        if (|req_valid) begin
          accept   = 1'b1;
          state_nx = CONV;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (rst) accept = 1'b0;
    req_ready = accept ? gnt : '0;
  end

  always_comb begin
    res = '0;
    if (opnd_op == ITOF) res[FW-1:0]    = itof_f;
    else                 res[width-1:0] = ftoi_q;
  end

  assign resp_valid = (state == RESP);

  // p0: operand capture on accept; p1: converter result into response register
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= IW'(nreq - 1);
      opnd_op     <= ITOF;
      opnd_signed <= 1'b0;
      opnd_data   <= '0;
      opnd_id     <= '0;
      resp_id     <= '0;
      resp_data   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        last_grant  <= gnt_idx;
        opnd_op     <= conv_op_t'(req_op[gnt_idx]);
        opnd_signed <= req_signed[gnt_idx];
        opnd_data   <= req_data[gnt_idx];
        opnd_id     <= gnt_idx;
      end
      if (state == CONV) begin
        resp_data <= res;
        resp_id   <= opnd_id;
      end
    end
  end

endmodule
